// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Used by fetch_buffer and fetch_unit.
package fetch_pkg;

  localparam logic [31:0] FETCH_NOP      = 32'h0000_0000;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundles for the fetch stage: instruction-memory handshake and decode-side link.
// Fetch is master on fetch_imem_if and slave on fetch_dec_if.
interface fetch_imem_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

interface fetch_dec_if;
  logic [31:0] Alt_PC;
  logic        Request_Alt_PC;
  logic        WANT_FREEZE;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr_PC_OUT;
  logic [31:0] Instr_PC_Plus4_OUT;

  modport master (output Alt_PC, Request_Alt_PC, WANT_FREEZE,
                  input  Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT);
  modport slave  (input  Alt_PC, Request_Alt_PC, WANT_FREEZE,
                  output Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT);
endinterface

// File: rtl/fetch_buffer.sv
// Small power-of-two FIFO of fetched {instr, pc} entries.
// Synchronous flush wins over push; a pop frees its slot for a same-edge push.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_entry_t             i_data,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = r_count[AW];
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake, fetch FIFO, redirect and freeze.
// Optional FETCH_STAT_EN adds saturating squash/bubble counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  fetch_imem_if.master  imem,
  fetch_dec_if.slave    dec
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0]   stat_squash_cnt,
  output logic [31:0]   stat_bubble_cnt
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_drain_addr;
  logic [31:0]   r_instr;
  logic [31:0]   r_pc;
  logic [31:0]   r_pc4;

  logic          w_req;
  logic [31:0]   w_addr;
  logic          w_ack;
  logic          w_redirect;
  logic          w_freeze;
  logic [31:0]   w_alt_pc;
  logic          w_enter_drain;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;

  assign w_redirect    = dec.Request_Alt_PC;
  assign w_freeze      = dec.WANT_FREEZE;
  assign w_alt_pc      = {dec.Alt_PC[31:2], 2'b00};
  assign w_ack         = w_req && imem.imem_ack;
  // An unanswered request cannot be withdrawn, so a redirect must wait it out in DRAIN.
  assign w_enter_drain = (r_state == REQ) && w_redirect && w_req && !w_ack;
  assign w_push        = (r_state == REQ) && w_ack && !w_redirect;
  assign w_pop         = !w_freeze && !w_redirect && !w_empty;
  assign w_push_data   = '{instr: imem.imem_data, pc: r_fetch_pc};

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk     (CLK),
    .rst_n   (RESET),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= IDLE;
      r_fetch_pc   <= RESET_PC;
      r_drain_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_redirect)  r_fetch_pc <= w_alt_pc;
      else if (w_push) r_fetch_pc <= pc_next(r_fetch_pc);
      if (w_enter_drain) r_drain_addr <= r_fetch_pc;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    w_state_nxt = REQ;
      REQ:     if (w_enter_drain) w_state_nxt = DRAIN;
      DRAIN:   if (w_ack) w_state_nxt = REQ;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_req  = 1'b0;
    w_addr = r_fetch_pc;
    unique case (r_state)
      REQ:     w_req = (w_count < CW'(BUF_DEPTH));
      DRAIN:   begin
        w_req  = 1'b1;
        w_addr = r_drain_addr;
      end
      default: w_req = 1'b0;
    endcase
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = w_addr;

  // Decode outputs: held while frozen, otherwise the FIFO head or a bubble.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_instr <= FETCH_NOP;
      r_pc    <= '0;
      r_pc4   <= '0;
    end else if (!w_freeze) begin
      if (w_pop) begin
        r_instr <= w_head.instr;
        r_pc    <= w_head.pc;
        r_pc4   <= pc_next(w_head.pc);
      end else begin
        r_instr <= FETCH_NOP;
        r_pc    <= '0;
        r_pc4   <= '0;
      end
    end
  end

  assign dec.Instr1_OUT         = r_instr;
  assign dec.Instr_PC_OUT       = r_pc;
  assign dec.Instr_PC_Plus4_OUT = r_pc4;

  a_push_has_room: assert property (@(posedge CLK) disable iff (!RESET)
    w_push |-> (!w_full || w_pop));

`ifdef FETCH_STAT_EN
  logic        w_squash;
  logic        w_bubble;
  logic [31:0] r_squash_cnt;
  logic [31:0] r_bubble_cnt;

  assign w_squash = w_ack && ((r_state == DRAIN) || w_redirect);
  assign w_bubble = !w_freeze && !w_pop;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_squash_cnt <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_squash && (r_squash_cnt != 32'hFFFF_FFFF)) r_squash_cnt <= r_squash_cnt + 32'd1;
      if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign stat_squash_cnt = r_squash_cnt;
  assign stat_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected PCs, monitors compare deliveries.
// A second instance with RESET_PC=32'hFFFF_FFF8 covers PC wrap-around after reset.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  fetch_imem_if imem_m ();
  fetch_dec_if  dec_m ();
  fetch_imem_if imem_w ();
  fetch_dec_if  dec_w ();

`ifdef FETCH_STAT_EN
  logic [31:0] sq_m, bb_m, sq_w, bb_w;
`endif

  fetch_unit #(.RESET_PC(32'h0040_0000), .BUF_DEPTH(2)) u_dut (
    .CLK   (clk),
    .RESET (rst_n),
    .imem  (imem_m),
    .dec   (dec_m)
`ifdef FETCH_STAT_EN
    , .stat_squash_cnt(sq_m), .stat_bubble_cnt(bb_m)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_dut_wrap (
    .CLK   (clk),
    .RESET (rst_n),
    .imem  (imem_w),
    .dec   (dec_w)
`ifdef FETCH_STAT_EN
    , .stat_squash_cnt(sq_w), .stat_bubble_cnt(bb_w)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[31:2], 2'b11};
  endfunction

  // Memory model for the main instance: acks after m_delay waiting cycles while budget lasts,
  // and checks that a pending request keeps req/addr stable.
  int unsigned m_budget = 0;
  int unsigned m_delay  = 0;
  int unsigned m_wait   = 0;
  logic        m_pend   = 1'b0;
  logic [31:0] m_addr   = '0;

  always @(negedge clk) begin
    imem_m.imem_ack  = 1'b0;
    imem_m.imem_data = '0;
    if (!rst_n) begin
      m_pend = 1'b0;
    end else begin
      if (m_pend) begin
        check("req_held", 32'(imem_m.imem_req), 32'd1);
        check("addr_held", imem_m.imem_addr, m_addr);
      end
      if (imem_m.imem_req) begin
        if (!m_pend) begin
          m_pend = 1'b1;
          m_addr = imem_m.imem_addr;
          m_wait = 0;
        end
        if (m_budget > 0 && m_wait >= m_delay) begin
          imem_m.imem_ack  = 1'b1;
          imem_m.imem_data = mem_word(imem_m.imem_addr);
          m_budget--;
          m_pend = 1'b0;
        end else begin
          m_wait++;
        end
      end
    end
  end

  int unsigned wm_budget = 0;
  always @(negedge clk) begin
    imem_w.imem_ack  = 1'b0;
    imem_w.imem_data = '0;
    if (rst_n && imem_w.imem_req && wm_budget > 0) begin
      imem_w.imem_ack  = 1'b1;
      imem_w.imem_data = mem_word(imem_w.imem_addr);
      wm_budget--;
    end
  end

  logic [31:0] exp_m[$];
  logic [31:0] exp_w[$];
  int          mon_cyc = 0;
  int          deliv_cyc[$];

  // Monitor, main instance: frozen edges must hold, unfrozen edges deliver the queue head or a bubble.
  logic [31:0] held_i = '0, held_pc = '0, held_p4 = '0;
  always begin
    logic        frz;
    logic [31:0] e;
    @(posedge clk);
    frz = dec_m.WANT_FREEZE;
    #1;
    mon_cyc++;
    if (rst_n) begin
      if (frz) begin
        check("frz_instr", dec_m.Instr1_OUT, held_i);
        check("frz_pc", dec_m.Instr_PC_OUT, held_pc);
        check("frz_pc4", dec_m.Instr_PC_Plus4_OUT, held_p4);
      end else if (dec_m.Instr1_OUT != FETCH_NOP) begin
        if (exp_m.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL spurious_out: got pc %h, expected no delivery (t=%0t)", dec_m.Instr_PC_OUT, $time);
        end else begin
          e = exp_m.pop_front();
          deliv_cyc.push_back(mon_cyc);
          check("out_instr", dec_m.Instr1_OUT, mem_word(e));
          check("out_pc", dec_m.Instr_PC_OUT, e);
          check("out_pc4", dec_m.Instr_PC_Plus4_OUT, e + 32'd4);
        end
      end else begin
        check("bubble_pc", dec_m.Instr_PC_OUT, 32'h0);
        check("bubble_pc4", dec_m.Instr_PC_Plus4_OUT, 32'h0);
      end
    end
    held_i  = dec_m.Instr1_OUT;
    held_pc = dec_m.Instr_PC_OUT;
    held_p4 = dec_m.Instr_PC_Plus4_OUT;
  end

  // Monitor, wrap instance (never frozen).
  always begin
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (dec_w.Instr1_OUT != FETCH_NOP) begin
        if (exp_w.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL wrap_spurious: got pc %h, expected no delivery (t=%0t)", dec_w.Instr_PC_OUT, $time);
        end else begin
          e = exp_w.pop_front();
          check("wrap_instr", dec_w.Instr1_OUT, mem_word(e));
          check("wrap_pc", dec_w.Instr_PC_OUT, e);
          check("wrap_pc4", dec_w.Instr_PC_Plus4_OUT, e + 32'd4);
        end
      end else begin
        check("wrap_bubble_pc", dec_w.Instr_PC_OUT, 32'h0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_drained(input string name);
    int cyc = 0;
    while (exp_m.size() != 0 && cyc < 40) begin
      tick();
      cyc++;
    end
    check(name, 32'(exp_m.size()), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    dec_m.Alt_PC = '0;
    dec_m.Request_Alt_PC = 1'b0;
    dec_m.WANT_FREEZE = 1'b0;
    dec_w.Alt_PC = '0;
    dec_w.Request_Alt_PC = 1'b0;
    dec_w.WANT_FREEZE = 1'b0;
    tick(2);

    check("rst_instr", dec_m.Instr1_OUT, 32'h0);
    check("rst_pc", dec_m.Instr_PC_OUT, 32'h0);
    check("rst_pc4", dec_m.Instr_PC_Plus4_OUT, 32'h0);
    check("rst_req", 32'(imem_m.imem_req), 32'd0);
    check("rst_req_wrap", 32'(imem_w.imem_req), 32'd0);

    // 1: zero-wait memory, three sequential fetches
    m_delay = 0;
    m_budget = 3;
    exp_m.push_back(32'h0040_0000);
    exp_m.push_back(32'h0040_0004);
    exp_m.push_back(32'h0040_0008);
    rst_n = 1'b1;
    #1;
    check("idle_req", 32'(imem_m.imem_req), 32'd0);
    tick(1);
    check("t1_first_addr", imem_m.imem_addr, 32'h0040_0000);
    wait_drained("t1_drain");
    if (deliv_cyc.size() == 3) check("t1_back_to_back", 32'(deliv_cyc[2] - deliv_cyc[0]), 32'd2);
    else check("t1_delivery_count", 32'(deliv_cyc.size()), 32'd3);

    // 2: ack after three wait cycles
    m_delay = 3;
    m_wait = 0;
    m_budget = 1;
    exp_m.push_back(32'h0040_000C);
    check("t2_addr", imem_m.imem_addr, 32'h0040_000C);
    wait_drained("t2_drain");

    // 3: freeze for five edges while the FIFO fills
    dec_m.WANT_FREEZE = 1'b1;
    m_delay = 0;
    m_wait = 0;
    m_budget = 3;
    exp_m.push_back(32'h0040_0010);
    exp_m.push_back(32'h0040_0014);
    exp_m.push_back(32'h0040_0018);
    tick(2);
    check("t3_req_full", 32'(imem_m.imem_req), 32'd0);
    tick(3);
    dec_m.WANT_FREEZE = 1'b0;
    wait_drained("t3_drain");

    // 4: redirect while the request for 0x400024 is outstanding; 0x400020 sits in the FIFO
    m_budget = 2;
    m_wait = 0;
    exp_m.push_back(32'h0040_001C);
    tick(2);
    dec_m.Alt_PC = 32'h0040_0100;
    dec_m.Request_Alt_PC = 1'b1;
    tick(1);
    dec_m.Request_Alt_PC = 1'b0;
    check("t4_drain_req", 32'(imem_m.imem_req), 32'd1);
    check("t4_drain_addr", imem_m.imem_addr, 32'h0040_0024);
    m_budget = 1;
    m_wait = 0;
    tick(1);
    check("t4_new_req", 32'(imem_m.imem_req), 32'd1);
    check("t4_new_addr", imem_m.imem_addr, 32'h0040_0100);
    m_budget = 2;
    exp_m.push_back(32'h0040_0100);
    exp_m.push_back(32'h0040_0104);
    wait_drained("t4_drain");

    // 5: redirect, ack and freeze on the same edge; unaligned target is word-aligned
    dec_m.WANT_FREEZE = 1'b1;
    dec_m.Alt_PC = 32'h0040_0203;
    dec_m.Request_Alt_PC = 1'b1;
    m_budget = 1;
    m_wait = 0;
    tick(1);
    dec_m.Request_Alt_PC = 1'b0;
    check("t5_req", 32'(imem_m.imem_req), 32'd1);
    check("t5_addr", imem_m.imem_addr, 32'h0040_0200);
    tick(1);
    dec_m.WANT_FREEZE = 1'b0;
    m_budget = 1;
    exp_m.push_back(32'h0040_0200);
    wait_drained("t5_drain");
`ifdef FETCH_STAT_EN
    check("stat_squash", sq_m, 32'd2);
`endif

    // 6: asynchronous reset mid-request, then wrap-around fetch on the second instance
    check("t6_pre_req", 32'(imem_m.imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_instr", dec_m.Instr1_OUT, 32'h0);
    check("t6_rst_pc", dec_m.Instr_PC_OUT, 32'h0);
    check("t6_rst_pc4", dec_m.Instr_PC_Plus4_OUT, 32'h0);
    check("t6_rst_req", 32'(imem_m.imem_req), 32'd0);
    check("t6_rst_req_wrap", 32'(imem_w.imem_req), 32'd0);
    wm_budget = 3;
    exp_w.push_back(32'hFFFF_FFF8);
    exp_w.push_back(32'hFFFF_FFFC);
    exp_w.push_back(32'h0000_0000);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("t6_restart_addr", imem_m.imem_addr, 32'h0040_0000);
    check("t6_restart_wrap_addr", imem_w.imem_addr, 32'hFFFF_FFF8);
    for (int i = 0; i < 20 && exp_w.size() != 0; i++) tick();
    check("t6_wrap_drain", 32'(exp_w.size()), 32'd0);
    tick(3);
    check("final_main_empty", 32'(exp_m.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
